// File: rtl/lab3_keypad_pkg.sv
// Shared types, key map and small helpers for the lab 3 keypad scanner.
package lab3_keypad_pkg;

  // Scanner FSM states.
  typedef enum logic [2:0] {
    SCAN        = 3'd0,
    DEB_PRESS   = 3'd1,
    EMIT        = 3'd2,
    HOLD        = 3'd3,
    DEB_RELEASE = 3'd4
  } state_t;

  // Hex code of each key, indexed [row][col].
  localparam logic [3:0] KEYMAP [4][4] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'hE, 4'h0, 4'hF, 4'hD}
  };

  // Number of low (active) bits in an active-low row vector.
  function automatic logic [2:0] one_cold_count(input logic [3:0] v);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 4; i++) begin
      if (!v[i]) begin
        n = n + 3'd1;
      end else begin
        n = n;
      end
    end
    return n;
  endfunction

  // Index of the lowest low bit; only meaningful when exactly one bit is low.
  function automatic logic [1:0] low_index(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!v[i]) begin
        idx = 2'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  // One-cold column drive pattern for a column index.
  function automatic logic [3:0] col_drive(input logic [1:0] c);
    return ~(4'b0001 << c);
  endfunction

endpackage

// File: rtl/lab3_sync.sv
// Parameterized-width two-flop synchronizer with async active-low reset.
module lab3_sync #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_r;
  logic [WIDTH-1:0] sync_r;

  // Two-stage capture of the asynchronous input; both stages clear on reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_r <= {WIDTH{1'b0}};
      sync_r <= {WIDTH{1'b0}};
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/lab3_keypad_scan.sv
// 4x4 matrix keypad scanner: column scan, press/release debounce and a
// single-cycle strobe carrying the hex code of each accepted key.
module lab3_keypad_scan
  import lab3_keypad_pkg::*;
#(
  parameter int SETTLE_CYCLES   = 1000,
  parameter int DEBOUNCE_CYCLES = 240000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] key_code,
  output logic       key_valid
);

  localparam int MAX_CYC = (SETTLE_CYCLES > DEBOUNCE_CYCLES) ? SETTLE_CYCLES : DEBOUNCE_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 2) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO    = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  logic [3:0]       rows_s;
  state_t           state_r,   state_s;
  logic [CNT_W-1:0] cnt_r,     cnt_s;
  logic [1:0]       col_r,     col_s;
  logic [1:0]       row_sel_r, row_sel_s;
  logic             row_bit_s;
  logic [3:0]       cols_r;
  logic [3:0]       key_code_r;
  logic             key_valid_r;

  lab3_sync #(.WIDTH(4)) u_rows_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rows),
    .q     (rows_s)
  );

  // Level of the locked row; only this row matters once a key is latched.
  assign row_bit_s = rows_s[row_sel_r];

  // Next-state logic for the FSM, the shared counter and the column/row latches.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    col_s     = col_r;
    row_sel_s = row_sel_r;
    case (state_r)
      SCAN: begin
        if (cnt_r == SETTLE_LAST) begin
          cnt_s = CNT_ZERO;
          if (one_cold_count(rows_s) == 3'd1) begin
            row_sel_s = low_index(rows_s);
            state_s   = DEB_PRESS;
          end else begin
            col_s = col_r + 2'd1;
          end
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      DEB_PRESS: begin
        if (row_bit_s) begin
          state_s = SCAN;
          col_s   = col_r + 2'd1;
          cnt_s   = CNT_ZERO;
        end else if (cnt_r == DEB_LAST) begin
          state_s = EMIT;
          cnt_s   = CNT_ZERO;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      EMIT: begin
        state_s = HOLD;
        cnt_s   = CNT_ZERO;
      end
      HOLD: begin
        if (row_bit_s) begin
          state_s = DEB_RELEASE;
          cnt_s   = CNT_ZERO;
        end else begin
          cnt_s = CNT_ZERO;
        end
      end
      DEB_RELEASE: begin
        if (!row_bit_s) begin
          state_s = HOLD;
          cnt_s   = CNT_ZERO;
        end else if (cnt_r == DEB_LAST) begin
          state_s = SCAN;
          col_s   = col_r + 2'd1;
          cnt_s   = CNT_ZERO;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_s   = SCAN;
        cnt_s     = CNT_ZERO;
        col_s     = 2'd0;
        row_sel_s = 2'd0;
      end
    endcase
  end

  // FSM, counter and latch registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= SCAN;
      cnt_r     <= CNT_ZERO;
      col_r     <= 2'd0;
      row_sel_r <= 2'd0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      col_r     <= col_s;
      row_sel_r <= row_sel_s;
    end
  end

  // Registered outputs: column drive, key code and the strobe aligned with EMIT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cols_r      <= 4'b1110;
      key_code_r  <= 4'b0000;
      key_valid_r <= 1'b0;
    end else begin
      cols_r      <= col_drive(col_s);
      key_valid_r <= (state_s == EMIT);
      if (state_s == EMIT) begin
        key_code_r <= KEYMAP[row_sel_r][col_r];
      end else begin
        key_code_r <= key_code_r;
      end
    end
  end

  assign cols      = cols_r;
  assign key_code  = key_code_r;
  assign key_valid = key_valid_r;

endmodule
